rps_match_engine: RTL
=====================

RPS_MATCH_ENGINE -- requirements
Module: rps_match_engine

Interface
REQ-001 Parameter WIN_TARGET, default 2, meaning round wins needed to take the match (2 = best-of-3); legal range 1..(2^SCORE_W)-1.
REQ-002 Parameter SCORE_W, default 4, meaning width of each player score counter.
REQ-003 Parameter ROUND_W, default 6, meaning width of the rounds-played counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 ena  input  1  clock enable; low freezes every register except async reset.
REQ-007 p1_move, p2_move  input  2 each  move encoding: 00 stone, 01 paper, 10 scissors, 11 invalid.
REQ-008 start  input  1  round request; only its rising edge counts.
REQ-009 clear  input  1  synchronous match clear (level).
REQ-010 round_result  output  2  00 tie, 01 P1 wins, 10 P2 wins, 11 invalid.
REQ-011 result_valid  output  1  one-cycle pulse when round_result, scores and round_cnt have just updated.
REQ-012 p1_score, p2_score  output  SCORE_W each  round wins per player.
REQ-013 round_cnt  output  ROUND_W  rounds evaluated, including ties and invalids.
REQ-014 match_over  output  1  high while state is MATCH_OVER.
REQ-015 champion  output  2  01 P1, 10 P2, 00 while no match is decided.
REQ-016 state  output  3  current FSM encoding, for debug.

Function
REQ-017 FSM states: IDLE=000, EVAL=001, RESULT=010, MATCH_OVER=011; encodings 100-111 return to IDLE on the next enabled edge.
REQ-018 start_q registers start on every enabled edge; a rising edge is start=1 with start_q=0.
REQ-019 In IDLE, a rising edge of start latches p1_move/p2_move into internal registers and moves the FSM to EVAL; moves sampled at any other time are ignored.
REQ-020 In EVAL, the block evaluates the latched moves in one cycle: either move 11 -> 11; equal moves -> 00; stone beats scissors, paper beats stone, scissors beats paper.
REQ-021 On the EVAL-exit edge, round_result, the winning player's score (+1), and round_cnt (+1, saturating at all-ones) are registered; ties and invalids change no score.
REQ-022 After EVAL, if the updated score of either player equals WIN_TARGET, the FSM goes to MATCH_OVER and champion is set to that player; otherwise it goes to RESULT.
REQ-023 result_valid is high for exactly the first cycle in RESULT or MATCH_OVER after EVAL, giving a latency of 2 enabled cycles from the start rising edge being sampled.
REQ-024 RESULT returns to IDLE on the first enabled edge with start=0; holding start high keeps the FSM in RESULT and starts no new round.
REQ-025 MATCH_OVER holds scores, round_result and champion, and ignores start, until clear is asserted.
REQ-026 When clear=1 on an enabled edge, in any state, the block zeroes scores, round_cnt, round_result and champion and enters IDLE; clear has priority over start.
REQ-027 When clear and start rise on the same edge, no round is started; a new round needs a fresh start rising edge after clear is low.
REQ-028 round_result and the scores keep their last values across IDLE/RESULT until the next EVAL exit or clear.
REQ-029 With ena=0, state, counters, outputs and start_q are frozen, and a start edge seen only while ena=0 is not registered.

Reset
REQ-030 rst_n=0 forces at once: state IDLE, round_result 00, result_valid 0, scores 0, round_cnt 0, champion 00, match_over 0, start_q 0, latched moves 00.
REQ-031 Reset asserted mid-round (EVAL or RESULT) discards the round, with no score update and no result_valid pulse.
REQ-032 After rst_n deasserts with start already high, no round starts until start goes low and rises again.

Verification (WIN_TARGET=2)
REQ-033 Run moves P1=00, P2=10 with a start pulse -> 2 cycles later result_valid=1, round_result=01, p1_score=1, round_cnt=1, state=010.
REQ-034 Run moves 01/01, then 11/00 -> round_result 00, then 11; scores unchanged and round_cnt increments by 2.
REQ-035 Play P2 winning two rounds (00 vs 01, twice) -> state=011, match_over=1, champion=10, p2_score=2; a further start pulse is ignored.
REQ-036 In MATCH_OVER raise clear together with start -> next state IDLE, all scores, round_cnt and champion 0, and no EVAL entered.
REQ-037 Hold start high for 10 cycles -> exactly one round is evaluated; change moves while in RESULT -> the recorded result reflects the moves latched at the start edge.
REQ-038 Assert rst_n=0 during EVAL, and separately drop ena for 3 cycles in EVAL -> reset: all outputs 0 with no pulse; ena drop: result is delayed by 3 cycles and is otherwise identical.

Source files
------------

// File: rtl/rps_match_engine_if.sv
// ---------------------------------------------------------------------------
// rps_match_engine_if
//   Bundles the control, move and status signals of rps_match_engine so the
//   engine and its driver share one connection.
//
//   master : drives ena, p1_move, p2_move, start, clear; observes status
//   slave  : the engine side (inputs/outputs mirrored)
//
//   Signals
//     ena            clock enable (low freezes the engine)
//     p1_move/p2_move 2-bit moves: 00 stone, 01 paper, 10 scissors, 11 invalid
//     start          round request, rising edge only
//     clear          synchronous match clear (level)
//     round_result   00 tie, 01 P1, 10 P2, 11 invalid
//     result_valid   one-cycle pulse after a round is scored
//     p1_score/p2_score  round wins per player
//     round_cnt      rounds evaluated (saturating)
//     match_over     high while the match is decided
//     champion       01 P1, 10 P2, 00 undecided
//     state          FSM encoding, for debug
// ---------------------------------------------------------------------------
interface rps_match_engine_if #(
   parameter int SCORE_W = 4,
   parameter int ROUND_W = 6
);
   logic               ena;
   logic [1:0]         p1_move;
   logic [1:0]         p2_move;
   logic               start;
   logic               clear;
   logic [1:0]         round_result;
   logic               result_valid;
   logic [SCORE_W-1:0] p1_score;
   logic [SCORE_W-1:0] p2_score;
   logic [ROUND_W-1:0] round_cnt;
   logic               match_over;
   logic [1:0]         champion;
   logic [2:0]         state;

   modport master (
      output ena, p1_move, p2_move, start, clear,
      input  round_result, result_valid, p1_score, p2_score,
             round_cnt, match_over, champion, state
   );

   modport slave (
      input  ena, p1_move, p2_move, start, clear,
      output round_result, result_valid, p1_score, p2_score,
             round_cnt, match_over, champion, state
   );
endinterface

// File: rtl/rps_match_engine.sv
// ---------------------------------------------------------------------------
// rps_match_engine
//   Rock-paper-scissors match referee. A rising edge of start in IDLE latches
//   both moves; the next enabled cycle judges them, updates scores and the
//   round counter, and pulses result_valid. The first player to reach
//   WIN_TARGET round wins takes the match, which then holds until clear.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    rps_match_engine_if.slave (controls, moves, status outputs)
// ---------------------------------------------------------------------------
module rps_match_engine #(
   parameter int WIN_TARGET = 2,
   parameter int SCORE_W    = 4,
   parameter int ROUND_W    = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rps_match_engine_if.slave    bus
);

   typedef enum logic [2:0] {
      IDLE       = 3'b000,
      EVAL       = 3'b001,
      RESULT     = 3'b010,
      MATCH_OVER = 3'b011
   } state_t;

   localparam logic [1:0] RES_TIE     = 2'b00;
   localparam logic [1:0] RES_P1      = 2'b01;
   localparam logic [1:0] RES_P2      = 2'b10;
   localparam logic [1:0] RES_INVALID = 2'b11;

   localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

   state_t             state_r;
   logic               start_q;
   // Set once start has been seen low; keeps a start that was already high
   // when reset released from counting as a rising edge.
   logic               start_armed;
   logic [1:0]         p1_lat;
   logic [1:0]         p2_lat;
   logic [1:0]         round_result_r;
   logic               result_valid_r;
   logic [SCORE_W-1:0] p1_score_r;
   logic [SCORE_W-1:0] p2_score_r;
   logic [ROUND_W-1:0] round_cnt_r;
   logic               match_over_r;
   logic [1:0]         champion_r;

   logic               start_rise;
   logic [1:0]         judged;
   logic [SCORE_W-1:0] p1_score_nx;
   logic [SCORE_W-1:0] p2_score_nx;

   function automatic logic [1:0] judge(input logic [1:0] m1, input logic [1:0] m2);
      if (m1 == 2'b11 || m2 == 2'b11)
         return RES_INVALID;
      else if (m1 == m2)
         return RES_TIE;
      // stone>scissors, paper>stone, scissors>paper
      else if ((m1 == 2'b00 && m2 == 2'b10) ||
               (m1 == 2'b01 && m2 == 2'b00) ||
               (m1 == 2'b10 && m2 == 2'b01))
         return RES_P1;
      else
         return RES_P2;
   endfunction

   assign start_rise = bus.start & ~start_q & start_armed;

   // NOTE: every output of always_comb gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      judged      = judge(p1_lat, p2_lat);
      p1_score_nx = p1_score_r;
      p2_score_nx = p2_score_r;
      if (judged == RES_P1) p1_score_nx = p1_score_r + SCORE_W'(1);
      if (judged == RES_P2) p2_score_nx = p2_score_r + SCORE_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         start_q        <= 1'b0;
         start_armed    <= 1'b0;
         p1_lat         <= 2'b00;
         p2_lat         <= 2'b00;
         round_result_r <= RES_TIE;
         result_valid_r <= 1'b0;
         p1_score_r     <= '0;
         p2_score_r     <= '0;
         round_cnt_r    <= '0;
         match_over_r   <= 1'b0;
         champion_r     <= 2'b00;
      end else if (bus.ena) begin
         start_q        <= bus.start;
         start_armed    <= start_armed | ~bus.start;
         result_valid_r <= 1'b0;

         if (bus.clear) begin
            state_r        <= IDLE;
            round_result_r <= RES_TIE;
            p1_score_r     <= '0;
            p2_score_r     <= '0;
            round_cnt_r    <= '0;
            match_over_r   <= 1'b0;
            champion_r     <= 2'b00;
         end else begin
            case (state_r)
               IDLE: begin
                  if (start_rise) begin
                     p1_lat  <= bus.p1_move;
                     p2_lat  <= bus.p2_move;
                     state_r <= EVAL;
                  end
               end

               EVAL: begin
                  round_result_r <= judged;
                  p1_score_r     <= p1_score_nx;
                  p2_score_r     <= p2_score_nx;
                  result_valid_r <= 1'b1;
                  if (round_cnt_r != '1)
                     round_cnt_r <= round_cnt_r + ROUND_W'(1);

                  if (p1_score_nx == TARGET) begin
                     state_r      <= MATCH_OVER;
                     match_over_r <= 1'b1;
                     champion_r   <= RES_P1;
                  end else if (p2_score_nx == TARGET) begin
                     state_r      <= MATCH_OVER;
                     match_over_r <= 1'b1;
                     champion_r   <= RES_P2;
                  end else begin
                     state_r <= RESULT;
                  end
               end

               // Holding start high parks here; only a low start releases.
               RESULT: begin
                  if (!bus.start) state_r <= IDLE;
               end

               MATCH_OVER: state_r <= MATCH_OVER;

               default: begin
                  state_r      <= IDLE;
                  match_over_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.round_result = round_result_r;
   assign bus.result_valid = result_valid_r;
   assign bus.p1_score     = p1_score_r;
   assign bus.p2_score     = p2_score_r;
   assign bus.round_cnt    = round_cnt_r;
   assign bus.match_over   = match_over_r;
   assign bus.champion     = champion_r;
   assign bus.state        = state_r;

endmodule
